// File: rtl/jk_mod_counter_pkg.sv
// Shared definitions for the JK modulo counter: J/K pair encodings and
// the MOD/WIDTH legality check used at elaboration.
// No logic lives here; everything is constant or a pure function.
package jk_mod_counter_pkg;

  // {j,k} excitation encodings
  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_RST  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;

  // Legal modulus is at least 2 and fits in WIDTH bits of state
  function automatic bit mod_width_legal(input int unsigned mod, input int unsigned width);
    return (mod >= 2) && (width >= 1) && (width < 32) &&
           ((64'd1 << width) >= 64'(mod));
  endfunction

endpackage

// File: rtl/jk_bit_cell.sv
// Single JK storage bit with synchronous active-high clear.
// Latency: q reflects J/K one rising edge after they are sampled.
// No flow control; the cell updates every edge.
module jk_bit_cell
  import jk_mod_counter_pkg::*;
(
  input  logic clk,
  input  logic clear,
  input  logic j,
  input  logic k,
  output logic q
);

  logic q_d;
  logic q_q;

  // JK characteristic: hold, reset, set, toggle
  always_comb begin
    q_d = q_q;
    case ({j, k})
      JK_HOLD: q_d = q_q;
      JK_RST:  q_d = 1'b0;
      JK_SET:  q_d = 1'b1;
      JK_TGL:  q_d = ~q_q;
      default: q_d = q_q;
    endcase
  end

  // State register with synchronous clear
  always_ff @(posedge clk) begin
    if (clear) q_q <= 1'b0;
    else       q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/jk_mod_counter.sv
// Modulo-MOD up/down counter whose state is a bank of JK cells driven by
// minimal-toggle J/K excitation; j_vec/k_vec/tc are same-cycle combinational,
// count/wrap/load_err change one edge after the controls. No backpressure.
module jk_mod_counter
  import jk_mod_counter_pkg::*;
#(
  parameter int unsigned MOD   = 10,
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] j_vec,
  output logic [WIDTH-1:0] k_vec,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
);

  // Terminal value is MOD-1, not all-ones, so non-power-of-two moduli
  // never step into unreachable states.
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MOD - 1);
  localparam logic [WIDTH:0]   MOD_W = (WIDTH + 1)'(MOD);
  localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);

  if (!mod_width_legal(MOD, WIDTH)) begin : g_param_check
    $error("jk_mod_counter: illegal MOD=%0d for WIDTH=%0d", MOD, WIDTH);
  end

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] nxt;
  logic             load_oor;
  logic             tc_c;
  logic             wrap_d;
  logic             wrap_q;
  logic             load_err_d;
  logic             load_err_q;

  // Next-state selection: clear > load > count step > hold
  always_comb begin
    load_oor = ({1'b0, load_val} >= MOD_W);
    nxt      = cnt;
    if (clear) begin
      nxt = '0;
    end else if (load) begin
      nxt = load_oor ? MAX_V : load_val;
    end else if (en) begin
      if (up) nxt = (cnt == MAX_V) ? '0 : (cnt + ONE_V);
      else    nxt = (cnt == '0) ? MAX_V : (cnt - ONE_V);
    end
  end

  // Terminal count and the flag inputs for the coming edge
  always_comb begin
    tc_c       = en & ~load & ~clear &
                 ((up & (cnt == MAX_V)) | (~up & (cnt == '0)));
    wrap_d     = tc_c;
    load_err_d = load & ~clear & load_oor;
  end

  // Minimal-toggle excitation: set only rising bits, reset only falling bits
  assign j_vec = ~cnt & nxt;
  assign k_vec = cnt & ~nxt;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bank
    jk_bit_cell u_bit (
      .clk   (clk),
      .clear (clear),
      .j     (j_vec[i]),
      .k     (k_vec[i]),
      .q     (cnt[i])
    );
  end

  // One-cycle flag pulses registered from the causing edge
  always_ff @(posedge clk) begin
    if (clear) begin
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign count    = cnt;
  assign tc       = tc_c;
  assign wrap     = wrap_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_jk_mod_counter.sv
// Bench for jk_mod_counter: three instances (MOD 2, 10, 16) share stimulus;
// expected edge results are queued when stimulus is driven and compared
// after the edge, combinational outputs are compared before the edge.
module tb_jk_mod_counter;

  localparam int NI = 3;
  localparam int MODS [NI] = '{2, 10, 16};

  typedef struct packed {
    logic [NI-1:0][3:0] cnt;
    logic [NI-1:0]      wrap;
    logic [NI-1:0]      lerr;
  } exp_t;

  logic       clk = 1'b0;
  logic       clear = 1'b1;
  logic       en = 1'b0;
  logic       up = 1'b1;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'd0;

  logic [NI-1:0][3:0] cnt_o;
  logic [NI-1:0][3:0] j_o;
  logic [NI-1:0][3:0] k_o;
  logic [NI-1:0]      tc_o;
  logic [NI-1:0]      wrap_o;
  logic [NI-1:0]      lerr_o;

  logic [NI-1:0][3:0] ext_q;
  logic [3:0]         mdl_cnt [NI];
  exp_t               sb [$];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  jk_mod_counter #(.MOD(2), .WIDTH(4)) u_dut2 (
    .clk(clk), .clear(clear), .en(en), .up(up), .load(load), .load_val(load_val),
    .count(cnt_o[0]), .j_vec(j_o[0]), .k_vec(k_o[0]), .tc(tc_o[0]),
    .wrap(wrap_o[0]), .load_err(lerr_o[0]));

  jk_mod_counter #(.MOD(10), .WIDTH(4)) u_dut10 (
    .clk(clk), .clear(clear), .en(en), .up(up), .load(load), .load_val(load_val),
    .count(cnt_o[1]), .j_vec(j_o[1]), .k_vec(k_o[1]), .tc(tc_o[1]),
    .wrap(wrap_o[1]), .load_err(lerr_o[1]));

  jk_mod_counter #(.MOD(16), .WIDTH(4)) u_dut16 (
    .clk(clk), .clear(clear), .en(en), .up(up), .load(load), .load_val(load_val),
    .count(cnt_o[2]), .j_vec(j_o[2]), .k_vec(k_o[2]), .tc(tc_o[2]),
    .wrap(wrap_o[2]), .load_err(lerr_o[2]));

  // External JK cells wired only to the DUT excitation outputs
  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      for (int b = 0; b < 4; b++) begin
        if (clear) ext_q[i][b] <= 1'b0;
        else case ({j_o[i][b], k_o[i][b]})
          2'b01:   ext_q[i][b] <= 1'b0;
          2'b10:   ext_q[i][b] <= 1'b1;
          2'b11:   ext_q[i][b] <= ~ext_q[i][b];
          default: ext_q[i][b] <= ext_q[i][b];
        endcase
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] mdl_nxt(input int m, input logic [3:0] c, input logic clr,
                                         input logic ld, input logic [3:0] lv,
                                         input logic e, input logic u);
    if (clr)     return 4'd0;
    else if (ld) return (int'(lv) < m) ? lv : 4'(m - 1);
    else if (e) begin
      if (u) return (int'(c) == m - 1) ? 4'd0 : 4'(c + 4'd1);
      else   return (c == 4'd0) ? 4'(m - 1) : 4'(c - 4'd1);
    end
    return c;
  endfunction

  // Apply controls before the edge and check combinational outputs
  task automatic drive(input logic c, input logic ld, input logic [3:0] lv,
                       input logic e, input logic u);
    exp_t ex;
    logic [3:0] nx;
    logic t;
    @(negedge clk);
    clear = c; load = ld; load_val = lv; en = e; up = u;
    #1;
    for (int i = 0; i < NI; i++) begin
      nx = mdl_nxt(MODS[i], mdl_cnt[i], c, ld, lv, e, u);
      t  = e & ~ld & ~c & ((u & (int'(mdl_cnt[i]) == MODS[i] - 1)) | (~u & (mdl_cnt[i] == 4'd0)));
      chk($sformatf("m%0d_tc", MODS[i]), 32'(tc_o[i]), 32'(t));
      chk($sformatf("m%0d_j_vec", MODS[i]), 32'(j_o[i]), 32'(~mdl_cnt[i] & nx));
      chk($sformatf("m%0d_k_vec", MODS[i]), 32'(k_o[i]), 32'(mdl_cnt[i] & ~nx));
      chk($sformatf("m%0d_jk_both", MODS[i]), 32'(j_o[i] & k_o[i]), 32'd0);
      chk($sformatf("m%0d_cnt_lt_mod", MODS[i]), 32'(int'(cnt_o[i]) < MODS[i]), 32'd1);
      ex.cnt[i]  = nx;
      ex.wrap[i] = t;
      ex.lerr[i] = ld & ~c & (int'(lv) >= MODS[i]);
    end
    sb.push_back(ex);
  endtask

  // Take the edge and compare registered results against the queue
  task automatic step();
    exp_t ex;
    @(posedge clk);
    #1;
    chk("sb_level", 32'(sb.size()), 32'd1);
    if (sb.size() == 0) return;
    ex = sb.pop_front();
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("m%0d_count", MODS[i]), 32'(cnt_o[i]), 32'(ex.cnt[i]));
      chk($sformatf("m%0d_wrap", MODS[i]), 32'(wrap_o[i]), 32'(ex.wrap[i]));
      chk($sformatf("m%0d_load_err", MODS[i]), 32'(lerr_o[i]), 32'(ex.lerr[i]));
      chk($sformatf("m%0d_ext_bank", MODS[i]), 32'(ext_q[i]), 32'(ex.cnt[i]));
      mdl_cnt[i] = ex.cnt[i];
    end
  endtask

  task automatic cyc(input logic c, input logic ld, input logic [3:0] lv,
                     input logic e, input logic u);
    drive(c, ld, lv, e, u);
    step();
  endtask

  initial begin
    // Bring all instances to a known state
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      mdl_cnt[i] = 4'd0;
      chk($sformatf("m%0d_rst_count", MODS[i]), 32'(cnt_o[i]), 32'd0);
      chk($sformatf("m%0d_rst_wrap", MODS[i]), 32'(wrap_o[i]), 32'd0);
      chk($sformatf("m%0d_rst_load_err", MODS[i]), 32'(lerr_o[i]), 32'd0);
    end

    // Clear overrides load and enable from count 7
    cyc(1'b0, 1'b1, 4'd7, 1'b0, 1'b1);
    chk("pre_clear_count", 32'(cnt_o[1]), 32'd7);
    cyc(1'b1, 1'b1, 4'd7, 1'b1, 1'b1);
    chk("clear_count", 32'(cnt_o[1]), 32'd0);
    chk("clear_wrap", 32'(wrap_o[1]), 32'd0);
    chk("clear_load_err", 32'(lerr_o[1]), 32'd0);

    // Up wrap at MOD=10
    cyc(1'b0, 1'b1, 4'd9, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    chk("up_wrap_tc", 32'(tc_o[1]), 32'd1);
    chk("up_wrap_j", 32'(j_o[1]), 32'b0000);
    chk("up_wrap_k", 32'(k_o[1]), 32'b1001);
    step();
    chk("up_wrap_count", 32'(cnt_o[1]), 32'd0);
    chk("up_wrap_pulse", 32'(wrap_o[1]), 32'd1);
    cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    chk("up_wrap_pulse_end", 32'(wrap_o[1]), 32'd0);

    // Down wrap from 0
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    chk("dn_wrap_tc", 32'(tc_o[1]), 32'd1);
    chk("dn_wrap_j", 32'(j_o[1]), 32'b1001);
    chk("dn_wrap_k", 32'(k_o[1]), 32'b0000);
    step();
    chk("dn_wrap_count", 32'(cnt_o[1]), 32'd9);
    chk("dn_wrap_pulse", 32'(wrap_o[1]), 32'd1);
    cyc(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    chk("dn_wrap_pulse_end", 32'(wrap_o[1]), 32'd0);

    // Out-of-range load saturates to MOD-1
    cyc(1'b0, 1'b1, 4'd12, 1'b0, 1'b1);
    chk("oor_load_count", 32'(cnt_o[1]), 32'd9);
    chk("oor_load_err", 32'(lerr_o[1]), 32'd1);
    cyc(1'b0, 1'b1, 4'd5, 1'b0, 1'b1);
    chk("ok_load_count", 32'(cnt_o[1]), 32'd5);
    chk("ok_load_err", 32'(lerr_o[1]), 32'd0);

    // Load beats enable at the terminal value
    cyc(1'b0, 1'b1, 4'd9, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 4'd3, 1'b1, 1'b1);
    chk("prio_tc", 32'(tc_o[1]), 32'd0);
    step();
    chk("prio_count", 32'(cnt_o[1]), 32'd3);
    chk("prio_wrap", 32'(wrap_o[1]), 32'd0);

    // Random traffic
    for (int n = 0; n < 2000; n++) begin
      cyc(1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 7) == 0),
          4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0),
          1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
